controlunit_mc: RTL and testbench
=================================

CONTROLUNIT_MC -- requirements
Module: controlunit_mc

Interface
REQ-001 Parameter OPW, default 2: opcode width; legal range is 2 or more.
REQ-002 Parameter SELW, default 2: insel width; legal range is 1 up to OPW.
REQ-003 Parameter EXEC_CYCLES, default 1: length of the EXEC phase in cycles; legal range is 1 to 15.
REQ-004 Port clk, input, 1 bit: single clock; every state element updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 Port instr_valid, input, 1 bit: an opcode is offered this cycle.
REQ-007 Port instr_ready, output, 1 bit: the block can accept an opcode this cycle.
REQ-008 Port opcode, input, OPW bits: instruction opcode, sampled only on accept.
REQ-009 Port stall, input, 1 bit: freezes the EXEC phase while high.
REQ-010 Port insel, output, SELW bits: datapath input select.
REQ-011 Port immsel, output, 1 bit: selects the immediate operand.
REQ-012 Port regwrite, output, 1 bit: register-file write enable, one-cycle pulse.
REQ-013 Port busy, output, 1 bit: an instruction is in flight.
REQ-014 Port done, output, 1 bit: one-cycle pulse marking completion of a legal instruction.
REQ-015 Port illegal, output, 1 bit: one-cycle pulse marking an illegal opcode.

Function
REQ-016 Accept SHALL occur on a rising edge where instr_valid=1 and instr_ready=1; the opcode is latched on that edge.
REQ-017 instr_ready SHALL equal (state==IDLE), decoded combinationally from the state register; all other outputs are registered.
REQ-018 The instruction class SHALL be decoded from latched opcode[1:0]: 00 IMM (immsel=1, writes), 01 REG (immsel=0, writes), 11 NOWB (immsel=0, no write), 10 ILLEGAL. Opcode bits above bit 1 SHALL NOT affect the class.
REQ-019 insel SHALL be loaded with opcode[SELW-1:0], and immsel per class, on the accept edge; both SHALL hold until the next accept or reset.
REQ-020 States: IDLE, DECODE, EXEC, WB.
- IDLE to DECODE on accept.
- DECODE to IDLE if the class is ILLEGAL, otherwise to EXEC.
- EXEC to WB after EXEC_CYCLES non-stalled cycles.
- WB to IDLE unconditionally.
REQ-021 In EXEC, a cycle counter SHALL advance only when stall=0; stall in any other state SHALL have no effect.
REQ-022 regwrite SHALL be 1 only during the WB cycle, and only for IMM or REG; done SHALL be 1 during the WB cycle for every legal class.
REQ-023 illegal SHALL be 1 only during the DECODE cycle of an ILLEGAL opcode; regwrite and done SHALL stay 0 for that instruction.
REQ-024 busy SHALL be 1 in DECODE, EXEC and WB, and 0 in IDLE.
REQ-025 Latency for a legal instruction accepted in cycle 0 with no stall: WB in cycle 2+EXEC_CYCLES, instr_ready=1 in cycle 3+EXEC_CYCLES. Each stall cycle adds exactly one cycle.
REQ-026 instr_valid while instr_ready=0 SHALL be ignored, with no queuing.
REQ-027 An opcode change while not accepting SHALL NOT alter any output.

Reset
REQ-028 rst=1 on a rising edge SHALL force state=IDLE, counter=0, insel=0, immsel=0, regwrite=0, busy=0, done=0 and illegal=0; instr_ready SHALL be 1 in the cycle after.
REQ-029 rst SHALL take priority over accept, stall and every state transition.
REQ-030 A reset mid-instruction SHALL abort it with no regwrite, done or illegal pulse.

Structure
REQ-031 Package controlunit_pkg SHALL hold the state encoding (IDLE, DECODE, EXEC, WB) and the class constants (IMM=2'b00, REG=2'b01, ILLEGAL=2'b10, NOWB=2'b11).
REQ-032 A single combinational sub-module, controlunit_opdecode, SHALL map opcode[1:0] to the class outputs {immsel, writes, illegal}.
REQ-033 The FSM, the EXEC counter and the output registers SHALL reside in controlunit_mc.

Verification
REQ-034 Reset then opcode=00 accepted in cycle 0, EXEC_CYCLES=1, no stall -> insel=0 and immsel=1 from cycle 1; regwrite=1 and done=1 in cycle 3 only; instr_ready=1 in cycle 4.
REQ-035 opcode=11 with EXEC_CYCLES=3 -> done=1 in cycle 5, regwrite=0 throughout, immsel=0.
REQ-036 opcode=01 with stall=1 in cycles 2 and 3, EXEC_CYCLES=1 -> WB in cycle 5; instr_ready and valid asserted in cycle 3 are ignored.
REQ-037 opcode=10 -> illegal=1 in cycle 1 only; instr_ready=1 in cycle 2; no regwrite or done.
REQ-038 rst asserted during EXEC of opcode=00 -> all outputs 0 next cycle and instr_ready=1; no regwrite at any point.
REQ-039 OPW=4, SELW=3, opcode=4'b1101 -> insel=3'b101, REG class, regwrite pulse in WB.

Source files
------------

// File: rtl/controlunit_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// instruction class codes and the EXEC counter width.
package controlunit_pkg;

  // FSM states of the control unit
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    WB     = 2'b11
  } state_e;

  // Instruction class, taken directly from opcode[1:0]
  localparam logic [1:0] IMM     = 2'b00;
  localparam logic [1:0] REG     = 2'b01;
  localparam logic [1:0] ILLEGAL = 2'b10;
  localparam logic [1:0] NOWB    = 2'b11;

  // EXEC counter width; holds up to EXEC_CYCLES-1 = 14
  localparam int CNTW = 4;

endpackage : controlunit_pkg

// File: rtl/controlunit_opdecode.sv
// Combinational opcode-class decoder: maps opcode[1:0] to the class
// attributes used by the control unit.
module controlunit_opdecode
  import controlunit_pkg::*;
(
  input  logic [1:0] op_cls,
  output logic       immsel,
  output logic       writes,
  output logic       illegal
);

  // Class attribute lookup; only the two low opcode bits matter
  always_comb begin
    immsel  = 1'b0;
    writes  = 1'b0;
    illegal = 1'b0;
    case (op_cls)
      IMM: begin
        immsel = 1'b1;
        writes = 1'b1;
      end
      REG: begin
        writes = 1'b1;
      end
      NOWB: begin
        writes = 1'b0;
      end
      ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule : controlunit_opdecode

// File: rtl/controlunit_mc.sv
// Multi-cycle control unit: accepts one opcode at a time, walks it through
// DECODE / EXEC / WB and produces registered datapath control signals.
module controlunit_mc
  import controlunit_pkg::*;
#(
  parameter int OPW         = 2,
  parameter int SELW        = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic            stall,
  output logic [SELW-1:0] insel,
  output logic            immsel,
  output logic            regwrite,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(EXEC_CYCLES - 1);

  state_e          state_q,    state_d;
  logic [CNTW-1:0] cnt_q,      cnt_d;
  logic [SELW-1:0] insel_q,    insel_d;
  logic            immsel_q,   immsel_d;
  logic            writes_q,   writes_d;
  logic            regwrite_q, regwrite_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic            illegal_q,  illegal_d;

  logic accept_s;
  logic dec_immsel_s;
  logic dec_writes_s;
  logic dec_illegal_s;

  controlunit_opdecode u_opdecode (
    .op_cls  (opcode[1:0]),
    .immsel  (dec_immsel_s),
    .writes  (dec_writes_s),
    .illegal (dec_illegal_s)
  );

  assign instr_ready = (state_q == IDLE);
  assign accept_s    = instr_valid & instr_ready;

  // Next-state, counter and next-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    insel_d   = insel_q;
    immsel_d  = immsel_q;
    writes_d  = writes_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = DECODE;
          cnt_d     = {CNTW{1'b0}};
          insel_d   = opcode[SELW-1:0];
          immsel_d  = dec_immsel_s;
          writes_d  = dec_writes_s;
          illegal_d = dec_illegal_s;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        // illegal_q is high exactly in the DECODE cycle of an illegal opcode
        if (illegal_q) begin
          state_d = IDLE;
        end else begin
          state_d = EXEC;
          cnt_d   = {CNTW{1'b0}};
        end
      end
      EXEC: begin
        if (stall) begin
          state_d = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WB;
          cnt_d   = {CNTW{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNTW{1'b0}};
      end
    endcase
    // Outputs are registered, so derive them from the state being entered
    regwrite_d = (state_d == WB) & writes_d;
    done_d     = (state_d == WB);
    busy_d     = (state_d != IDLE);
  end

  // State, counter and output registers with synchronous reset priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNTW{1'b0}};
      insel_q    <= {SELW{1'b0}};
      immsel_q   <= 1'b0;
      writes_q   <= 1'b0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      insel_q    <= insel_d;
      immsel_q   <= immsel_d;
      writes_q   <= writes_d;
      regwrite_q <= regwrite_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign insel    = insel_q;
  assign immsel   = immsel_q;
  assign regwrite = regwrite_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule : controlunit_mc

// File: tb/tb_controlunit_mc.sv
// Self-checking bench for controlunit_mc. Instance A (defaults) is checked
// through a pulse scoreboard plus directed checks; instance B (EXEC_CYCLES=3)
// and instance C (OPW=4, SELW=3) get directed per-cycle checks.
module tb_controlunit_mc;

  typedef struct {
    int         cyc;
    logic [2:0] pulses;  // {regwrite, done, illegal}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] op;
  logic       va, vb, vc;

  logic       rdy_a, rw_a, dn_a, il_a, busy_a, imm_a;
  logic [1:0] insel_a;
  logic       rdy_b, rw_b, dn_b, il_b, busy_b, imm_b;
  logic [1:0] insel_b;
  logic       rdy_c, rw_c, dn_c, il_c, busy_c, imm_c;
  logic [2:0] insel_c;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  controlunit_mc u_dut_a (
    .clk(clk), .rst(rst), .instr_valid(va), .instr_ready(rdy_a),
    .opcode(op[1:0]), .stall(stall), .insel(insel_a), .immsel(imm_a),
    .regwrite(rw_a), .busy(busy_a), .done(dn_a), .illegal(il_a)
  );

  controlunit_mc #(.EXEC_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .instr_valid(vb), .instr_ready(rdy_b),
    .opcode(op[1:0]), .stall(stall), .insel(insel_b), .immsel(imm_b),
    .regwrite(rw_b), .busy(busy_b), .done(dn_b), .illegal(il_b)
  );

  controlunit_mc #(.OPW(4), .SELW(3)) u_dut_c (
    .clk(clk), .rst(rst), .instr_valid(vc), .instr_ready(rdy_c),
    .opcode(op), .stall(stall), .insel(insel_c), .immsel(imm_c),
    .regwrite(rw_c), .busy(busy_c), .done(dn_c), .illegal(il_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at_cyc, input logic [2:0] pulses);
    exp_t e;
    e.cyc    = at_cyc;
    e.pulses = pulses;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor for instance A: pulses only where an entry is due
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        mon_e = sb_q.pop_front();
        chk("a_sb_pulse", {rw_a, dn_a, il_a}, mon_e.pulses);
      end else begin
        chk("a_no_pulse", {rw_a, dn_a, il_a}, 3'b000);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; op = 4'b0000;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_a", rdy_a, 1'b1);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_insel_a", insel_a, 2'b00);
    chk("rst_immsel_a", imm_a, 1'b0);
    chk("rst_pulses_a", {rw_a, dn_a, il_a}, 3'b000);
    chk("rst_ready_b", rdy_b, 1'b1);
    chk("rst_ready_c", rdy_c, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;

    // IMM opcode 00: WB in cycle 3, ready again in cycle 4
    @(negedge clk);
    va = 1'b1; op = 4'b0000; push(cyc + 3, 3'b110);
    @(negedge clk); va = 1'b0;
    chk("imm_insel_c1", insel_a, 2'b00);
    chk("imm_immsel_c1", imm_a, 1'b1);
    chk("imm_busy_c1", busy_a, 1'b1);
    chk("imm_ready_c1", rdy_a, 1'b0);
    @(negedge clk);
    chk("imm_ready_c2", rdy_a, 1'b0);
    @(negedge clk);
    chk("imm_busy_c3", busy_a, 1'b1);
    chk("imm_ready_c3", rdy_a, 1'b0);
    @(negedge clk);
    chk("imm_ready_c4", rdy_a, 1'b1);
    chk("imm_busy_c4", busy_a, 1'b0);
    chk("imm_immsel_hold", imm_a, 1'b1);

    // NOWB opcode 11 accepted back-to-back: done without regwrite
    va = 1'b1; op = 4'b0011; push(cyc + 3, 3'b010);
    @(negedge clk); va = 1'b0;
    chk("nowb_insel", insel_a, 2'b11);
    chk("nowb_immsel", imm_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("nowb_ready_c4", rdy_a, 1'b1);

    // REG opcode 01 with stall in cycles 2 and 3; valid in cycle 3 ignored
    va = 1'b1; op = 4'b0001; push(cyc + 5, 3'b110);
    @(negedge clk); va = 1'b0;
    @(negedge clk); stall = 1'b1;
    @(negedge clk);
    chk("stall_ready_c3", rdy_a, 1'b0);
    va = 1'b1; op = 4'b0000;
    @(negedge clk); stall = 1'b0; va = 1'b0;
    chk("stall_insel_c4", insel_a, 2'b01);
    chk("stall_immsel_c4", imm_a, 1'b0);
    chk("stall_busy_c4", busy_a, 1'b1);
    @(negedge clk);
    chk("stall_busy_c5", busy_a, 1'b1);
    @(negedge clk);
    chk("stall_ready_c6", rdy_a, 1'b1);
    chk("stall_busy_c6", busy_a, 1'b0);

    // ILLEGAL opcode 10 (stall in IDLE has no effect): illegal in cycle 1 only
    stall = 1'b1; va = 1'b1; op = 4'b0010; push(cyc + 1, 3'b001);
    @(negedge clk); stall = 1'b0; va = 1'b0;
    chk("ill_insel", insel_a, 2'b10);
    chk("ill_busy_c1", busy_a, 1'b1);
    chk("ill_ready_c1", rdy_a, 1'b0);
    @(negedge clk);
    chk("ill_ready_c2", rdy_a, 1'b1);
    chk("ill_busy_c2", busy_a, 1'b0);

    // Reset during EXEC of opcode 00 aborts with no WB pulse
    va = 1'b1; op = 4'b0000;
    @(negedge clk); va = 1'b0;
    @(negedge clk);
    chk("abort_busy_c2", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_ready", rdy_a, 1'b1);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_insel", insel_a, 2'b00);
    chk("abort_immsel", imm_a, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_idle", rdy_a, 1'b1);

    // Instance B, EXEC_CYCLES=3, opcode 11: done in cycle 5, ready in 6
    vb = 1'b1; op = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vb = 1'b0;
      chk("b_done", dn_b, (k == 5));
      chk("b_regwrite", rw_b, 1'b0);
      chk("b_immsel", imm_b, 1'b0);
      chk("b_ready", rdy_b, (k == 6));
      chk("b_busy", busy_b, (k < 6));
    end

    // Instance C, OPW=4 SELW=3, opcode 1101: REG class, insel 101
    vc = 1'b1; op = 4'b1101;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vc = 1'b0;
      chk("c_insel", insel_c, 3'b101);
      chk("c_immsel", imm_c, 1'b0);
      chk("c_regwrite", rw_c, (k == 3));
      chk("c_done", dn_c, (k == 3));
      chk("c_illegal", il_c, 1'b0);
      chk("c_ready", rdy_c, (k == 4));
    end

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_controlunit_mc
